memory_flip_ctrl: RTL and testbench
===================================

Name: memory_flip_ctrl

Overview:
- Turn sequencer for the memory-match game core.
- Owns cursor, pick-pair sequencing, match/reveal masks, reveal-hold timer and lives counter.
- Reads card values from the shuffled card array through a combinational read port.
- Sits between the button front end (debounced single-cycle pulses) and the memory core, VGA and SSD outputs.

Parameters:
- N_CARDS, 10, number of card slots (cursor range 0..N_CARDS-1).
- INIT_LIVES, 5, lives loaded at game start (1..15).
- SHOW_CYCLES, 100000000, Clk cycles a mismatched pair stays revealed (1 s at 100 MHz).
- TW, 27, width of the hold timer.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- Start  in  1  single-cycle pulse; begins a game from INIT.
- Ack  in  1  single-cycle pulse; leaves WIN/LOSE.
- Left, Right, Select  in  1 each  single-cycle debounced pulses.
- Rd_addr  out  4  card array read address, combinationally equal to Cursor.
- Rd_data  in  4  card value at Rd_addr, same cycle.
- Cursor  out  4  current slot index.
- Revealed  out  N_CARDS  face-up mask, including matched cards.
- Matched  out  N_CARDS  permanently matched mask.
- Lives  out  4  remaining lives.
- Qi, Qp1, Qp2, Qc, Qs, Qw, Ql  out  1 each  one-hot state flags.

Behaviour:
- Reset (Reset=0): state INIT.
  - Cursor=0, Revealed=0, Matched=0, Lives=0, timer=0, idx1=idx2=0, v1=0.
  - Qi=1, all other Q flags 0.
- INIT: on Start, load Lives=INIT_LIVES, clear both masks, Cursor=0, go PICK1.
- Cursor movement, in PICK1/PICK2 only:
  - Right increments Cursor, wrapping N_CARDS-1 -> 0.
  - Left decrements Cursor, wrapping 0 -> N_CARDS-1.
  - Left and Right in the same cycle: no move.
  - Select in the same cycle as Left/Right: Select wins, no move.
  - Moves in all other states are ignored.
- PICK1, Select:
  - Matched[Cursor]=1: ignore.
  - Otherwise: idx1<=Cursor, v1<=Rd_data, Revealed[Cursor]<=1, go PICK2.
- PICK2, Select:
  - Cursor==idx1 or Matched[Cursor]=1: ignore.
  - Otherwise: idx2<=Cursor, v2<=Rd_data, Revealed[Cursor]<=1, go CHECK.
- CHECK (exactly 1 cycle):
  - v1==v2: Matched[idx1]/[idx2]<=1. If Matched then becomes all-ones, go WIN; else go PICK1.
  - v1!=v2: Lives<=Lives-1, saturating at 0. Load timer=SHOW_CYCLES-1, go SHOW.
- SHOW:
  - Timer decrements each cycle.
  - In the cycle timer==0: clear Revealed[idx1] and Revealed[idx2]. Go LOSE if Lives==0, else PICK1.
  - Total hold is SHOW_CYCLES cycles in SHOW.
- WIN, LOSE: masks and Lives hold. On Ack go INIT; masks hold until the next Start.
- Start outside INIT is ignored. Ack outside WIN/LOSE is ignored.
- Matched bits never clear except via Start or Reset.
- Reset asserted mid-game (including during SHOW) aborts immediately to the reset values.
- All outputs are registered except Rd_addr.

Decomposition:
- Shared package memory_pkg:
  - State encoding localparams S_INIT, S_PICK1, S_PICK2, S_CHECK, S_SHOW, S_WIN, S_LOSE.
  - N_CARDS default.
  - Card value width (4).
- Sub-module memory_show_timer: loadable TW-bit down-counter with load, enable and zero flag.

Test Plan:
- Reset=0 mid-SHOW, then Reset=1 -> Qi=1, Lives=0, Revealed=0, Cursor=0 on the next edge check.
- Start; Left x1 -> Cursor=9. Right x1 -> Cursor=0. Left+Right same cycle -> Cursor unchanged.
- Cards {3,3,...}; Select@0, Right, Select@1 -> Qc one cycle, Matched=10'b0000000011, back in PICK1, Lives=5.
- Mismatch Select@0 (v=3), Select@2 (v=7), SHOW_CYCLES=4:
  - Lives 5 -> 4.
  - Revealed=10'b0000000101 for exactly 4 cycles of Qs, then 0.
  - Qp1=1 afterwards.
- PICK2 re-Select of idx1, and Select on a matched card -> ignored, state and masks unchanged.
- INIT_LIVES=1, one mismatch -> LOSE after SHOW, Ql=1. Ack -> Qi=1.
- Full solve of all 5 pairs -> Qw=1, Matched=all-ones. Start while in WIN is ignored.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for the memory-match turn sequencer: state encoding,
// default board size and card value width.
package memory_pkg;

    localparam int N_CARDS_DEF = 10;
    localparam int CARD_W      = 4;
    localparam int IDX_W       = 4;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_PICK1 = 3'd1,
        S_PICK2 = 3'd2,
        S_CHECK = 3'd3,
        S_SHOW  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    // Flag order {Qi, Qp1, Qp2, Qc, Qs, Qw, Ql}
    function automatic logic [6:0] state_onehot(input state_t s);
        logic [6:0] q;
        q = '0;
        case (s)
            S_INIT:  q = 7'b1000000;
            S_PICK1: q = 7'b0100000;
            S_PICK2: q = 7'b0010000;
            S_CHECK: q = 7'b0001000;
            S_SHOW:  q = 7'b0000100;
            S_WIN:   q = 7'b0000010;
            S_LOSE:  q = 7'b0000001;
            default: q = 7'b1000000;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/memory_show_timer.sv
// Loadable down-counter that times how long a mismatched pair stays face-up.
module memory_show_timer #(
    parameter int TW = 27
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/memory_flip_ctrl.sv
// Turn sequencer for the memory-match game: cursor, two-card picks, match and
// reveal masks, mismatch hold timer and lives.
module memory_flip_ctrl
    import memory_pkg::*;
#(
    parameter int N_CARDS     = N_CARDS_DEF,
    parameter int INIT_LIVES  = 5,
    parameter int SHOW_CYCLES = 100000000,
    parameter int TW          = 27
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_ack,
    input  logic               i_left,
    input  logic               i_right,
    input  logic               i_select,
    output logic [IDX_W-1:0]   o_rd_addr,
    input  logic [CARD_W-1:0]  i_rd_data,
    output logic [IDX_W-1:0]   o_cursor,
    output logic [N_CARDS-1:0] o_revealed,
    output logic [N_CARDS-1:0] o_matched,
    output logic [3:0]         o_lives,
    output logic               o_qi,
    output logic               o_qp1,
    output logic               o_qp2,
    output logic               o_qc,
    output logic               o_qs,
    output logic               o_qw,
    output logic               o_ql
);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CARDS - 1);
    localparam logic [TW-1:0]      HOLD_VAL = TW'(SHOW_CYCLES - 1);
    localparam logic [N_CARDS-1:0] ALL_SET  = '1;

    state_t              r_state,    w_state_next;
    logic [IDX_W-1:0]    r_cursor,   w_cursor_next;
    logic [N_CARDS-1:0]  r_revealed, w_revealed_next;
    logic [N_CARDS-1:0]  r_matched,  w_matched_next;
    logic [3:0]          r_lives,    w_lives_next;
    logic [IDX_W-1:0]    r_idx1,     w_idx1_next;
    logic [IDX_W-1:0]    r_idx2,     w_idx2_next;
    logic [CARD_W-1:0]   r_v1,       w_v1_next;
    logic [CARD_W-1:0]   r_v2,       w_v2_next;
    logic [6:0]          r_q,        w_q_next;
    logic                w_timer_load;
    logic                w_timer_zero;
    logic                w_can_move;
    logic                w_cur_matched;

    memory_show_timer #(.TW(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_timer_load),
        .i_load_val (HOLD_VAL),
        .i_en       (r_state == S_SHOW),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_INIT;
            r_cursor   <= '0;
            r_revealed <= '0;
            r_matched  <= '0;
            r_lives    <= '0;
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_v1       <= '0;
            r_v2       <= '0;
            r_q        <= state_onehot(S_INIT);
        end else begin
            r_state    <= w_state_next;
            r_cursor   <= w_cursor_next;
            r_revealed <= w_revealed_next;
            r_matched  <= w_matched_next;
            r_lives    <= w_lives_next;
            r_idx1     <= w_idx1_next;
            r_idx2     <= w_idx2_next;
            r_v1       <= w_v1_next;
            r_v2       <= w_v2_next;
            r_q        <= w_q_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cursor_next   = r_cursor;
        w_revealed_next = r_revealed;
        w_matched_next  = r_matched;
        w_lives_next    = r_lives;
        w_idx1_next     = r_idx1;
        w_idx2_next     = r_idx2;
        w_v1_next       = r_v1;
        w_v2_next       = r_v2;
        w_timer_load    = 1'b0;
        w_cur_matched   = r_matched[r_cursor];
        // Select takes priority over movement in the same cycle
        w_can_move      = ((r_state == S_PICK1) || (r_state == S_PICK2)) && !i_select;

        if (w_can_move) begin
            if (i_right && !i_left) begin
                w_cursor_next = (r_cursor == LAST_IDX) ? '0 : r_cursor + 1'b1;
            end else if (i_left && !i_right) begin
                w_cursor_next = (r_cursor == '0) ? LAST_IDX : r_cursor - 1'b1;
            end
        end

        case (r_state)
            S_INIT: begin
                if (i_start) begin
                    w_lives_next    = 4'(INIT_LIVES);
                    w_revealed_next = '0;
                    w_matched_next  = '0;
                    w_cursor_next   = '0;
                    w_state_next    = S_PICK1;
                end
            end
            S_PICK1: begin
                if (i_select && !w_cur_matched) begin
                    w_idx1_next               = r_cursor;
                    w_v1_next                 = i_rd_data;
                    w_revealed_next[r_cursor] = 1'b1;
                    w_state_next              = S_PICK2;
                end
            end
            S_PICK2: begin
                if (i_select && !w_cur_matched && (r_cursor != r_idx1)) begin
                    w_idx2_next               = r_cursor;
                    w_v2_next                 = i_rd_data;
                    w_revealed_next[r_cursor] = 1'b1;
                    w_state_next              = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_v1 == r_v2) begin
                    w_matched_next[r_idx1] = 1'b1;
                    w_matched_next[r_idx2] = 1'b1;
                    w_state_next = (w_matched_next == ALL_SET) ? S_WIN : S_PICK1;
                end else begin
                    w_lives_next = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;
                    w_timer_load = 1'b1;
                    w_state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                // Lives was already decremented in CHECK, so test the stored value
                if (w_timer_zero) begin
                    w_revealed_next[r_idx1] = 1'b0;
                    w_revealed_next[r_idx2] = 1'b0;
                    w_state_next = (r_lives == 4'd0) ? S_LOSE : S_PICK1;
                end
            end
            S_WIN, S_LOSE: begin
                if (i_ack) begin
                    w_state_next = S_INIT;
                end
            end
            default: w_state_next = S_INIT;
        endcase

        w_q_next = state_onehot(w_state_next);
    end

    assign o_rd_addr  = r_cursor;
    assign o_cursor   = r_cursor;
    assign o_revealed = r_revealed;
    assign o_matched  = r_matched;
    assign o_lives    = r_lives;
    assign o_qi       = r_q[6];
    assign o_qp1      = r_q[5];
    assign o_qp2      = r_q[4];
    assign o_qc       = r_q[3];
    assign o_qs       = r_q[2];
    assign o_qw       = r_q[1];
    assign o_ql       = r_q[0];

endmodule

// File: tb/tb_memory_flip_ctrl.sv
// Scoreboard bench for memory_flip_ctrl: each stimulus cycle queues the expected
// output snapshot {Q flags, lives, matched, revealed, cursor}; tasks drain and compare.
module tb_memory_flip_ctrl;

    localparam logic [6:0] QI  = 7'b1000000;
    localparam logic [6:0] QP1 = 7'b0100000;
    localparam logic [6:0] QP2 = 7'b0010000;
    localparam logic [6:0] QC  = 7'b0001000;
    localparam logic [6:0] QS  = 7'b0000100;
    localparam logic [6:0] QW  = 7'b0000010;
    localparam logic [6:0] QL  = 7'b0000001;

    // Stimulus encoding {left, right, select, start, ack}
    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] L   = 5'b10000;
    localparam logic [4:0] R   = 5'b01000;
    localparam logic [4:0] S   = 5'b00100;
    localparam logic [4:0] ST  = 5'b00010;
    localparam logic [4:0] AK  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] cards [10];

    logic l0 = 0, r0 = 0, s0 = 0, st0 = 0, ak0 = 0;
    logic [3:0] addr0, data0, cur0, lives0;
    logic [9:0] rev0, mat0;
    logic qi0, qp10, qp20, qc0, qs0, qw0, ql0;

    logic l1 = 0, r1 = 0, s1 = 0, st1 = 0, ak1 = 0;
    logic [3:0] addr1, data1, cur1, lives1;
    logic [9:0] rev1, mat1;
    logic qi1, qp11, qp21, qc1, qs1, qw1, ql1;

    logic [34:0] exp_q [$];
    logic [34:0] got_q [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign data0 = (addr0 < 4'd10) ? cards[addr0] : 4'd0;
    assign data1 = (addr1 < 4'd10) ? cards[addr1] : 4'd0;

    memory_flip_ctrl #(.N_CARDS(10), .INIT_LIVES(5), .SHOW_CYCLES(4), .TW(27)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st0), .i_ack(ak0),
        .i_left(l0), .i_right(r0), .i_select(s0),
        .o_rd_addr(addr0), .i_rd_data(data0), .o_cursor(cur0),
        .o_revealed(rev0), .o_matched(mat0), .o_lives(lives0),
        .o_qi(qi0), .o_qp1(qp10), .o_qp2(qp20), .o_qc(qc0),
        .o_qs(qs0), .o_qw(qw0), .o_ql(ql0)
    );

    memory_flip_ctrl #(.N_CARDS(10), .INIT_LIVES(1), .SHOW_CYCLES(4), .TW(27)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_ack(ak1),
        .i_left(l1), .i_right(r1), .i_select(s1),
        .o_rd_addr(addr1), .i_rd_data(data1), .o_cursor(cur1),
        .o_revealed(rev1), .o_matched(mat1), .o_lives(lives1),
        .o_qi(qi1), .o_qp1(qp11), .o_qp2(qp21), .o_qc(qc1),
        .o_qs(qs1), .o_qw(qw1), .o_ql(ql1)
    );

    function automatic logic [34:0] mk(input logic [6:0] q, input logic [3:0] lv,
                                       input logic [9:0] m, input logic [9:0] rv,
                                       input logic [3:0] c);
        return {q, lv, m, rv, c};
    endfunction

    function automatic logic [34:0] obs0();
        return {qi0, qp10, qp20, qc0, qs0, qw0, ql0, lives0, mat0, rev0, cur0};
    endfunction

    function automatic logic [34:0] obs1();
        return {qi1, qp11, qp21, qc1, qs1, qw1, ql1, lives1, mat1, rev1, cur1};
    endfunction

    // One clock of stimulus on the main DUT; expected snapshot queued with it
    task automatic apply0(input logic [4:0] stim, input logic [34:0] e);
        exp_q.push_back(e);
        {l0, r0, s0, st0, ak0} = stim;
        @(posedge clk); #1;
        {l0, r0, s0, st0, ak0} = '0;
        got_q.push_back(obs0());
    endtask

    task automatic apply1(input logic [4:0] stim, input logic [34:0] e);
        exp_q.push_back(e);
        {l1, r1, s1, st1, ak1} = stim;
        @(posedge clk); #1;
        {l1, r1, s1, st1, ak1} = '0;
        got_q.push_back(obs1());
    endtask

    task automatic test_reset();
        logic [34:0] e, g;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        got_q.push_back(obs0());
        rst_n = 1'b1;
        apply0(NOP, mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        apply0(R,   mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        apply0(AK,  mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL reset step %0d got=%h exp=%h", k, g, e); end
            else $display("reset step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_cursor();
        logic [34:0] e, g;
        apply0(ST,    mk(QP1, 4'd5, 10'h0, 10'h0, 4'd0));
        apply0(L,     mk(QP1, 4'd5, 10'h0, 10'h0, 4'd9));
        apply0(R,     mk(QP1, 4'd5, 10'h0, 10'h0, 4'd0));
        apply0(L | R, mk(QP1, 4'd5, 10'h0, 10'h0, 4'd0));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL cursor step %0d got=%h exp=%h", k, g, e); end
            else $display("cursor step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_mismatch();
        logic [34:0] e, g;
        apply0(S | L, mk(QP2, 4'd5, 10'h0, 10'h001, 4'd0));
        apply0(R,     mk(QP2, 4'd5, 10'h0, 10'h001, 4'd1));
        apply0(R,     mk(QP2, 4'd5, 10'h0, 10'h001, 4'd2));
        apply0(S,     mk(QC,  4'd5, 10'h0, 10'h005, 4'd2));
        apply0(NOP,   mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        apply0(L,     mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        apply0(NOP,   mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        apply0(NOP,   mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        apply0(NOP,   mk(QP1, 4'd4, 10'h0, 10'h000, 4'd2));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL mismatch step %0d got=%h exp=%h", k, g, e); end
            else $display("mismatch step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_match();
        logic [34:0] e, g;
        apply0(L,   mk(QP1, 4'd4, 10'h0, 10'h000, 4'd1));
        apply0(L,   mk(QP1, 4'd4, 10'h0, 10'h000, 4'd0));
        apply0(S,   mk(QP2, 4'd4, 10'h0, 10'h001, 4'd0));
        apply0(R,   mk(QP2, 4'd4, 10'h0, 10'h001, 4'd1));
        apply0(S,   mk(QC,  4'd4, 10'h0, 10'h003, 4'd1));
        apply0(NOP, mk(QP1, 4'd4, 10'h3, 10'h003, 4'd1));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL match step %0d got=%h exp=%h", k, g, e); end
            else $display("match step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_ignore();
        logic [34:0] e, g;
        apply0(S,   mk(QP1, 4'd4, 10'h3, 10'h003, 4'd1));
        apply0(ST,  mk(QP1, 4'd4, 10'h3, 10'h003, 4'd1));
        apply0(R,   mk(QP1, 4'd4, 10'h3, 10'h003, 4'd2));
        apply0(S,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd2));
        apply0(S,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd2));
        apply0(L,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd1));
        apply0(S,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd1));
        apply0(AK,  mk(QP2, 4'd4, 10'h3, 10'h007, 4'd1));
        apply0(R,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd2));
        apply0(R,   mk(QP2, 4'd4, 10'h3, 10'h007, 4'd3));
        apply0(S,   mk(QC,  4'd4, 10'h3, 10'h00F, 4'd3));
        apply0(NOP, mk(QP1, 4'd4, 10'hF, 10'h00F, 4'd3));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL ignore step %0d got=%h exp=%h", k, g, e); end
            else $display("ignore step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_full_solve();
        logic [34:0] e, g;
        logic [9:0] m, rv;
        m = 10'h00F;
        for (int p = 4; p < 10; p += 2) begin
            apply0(R, mk(QP1, 4'd4, m, m, 4'(p)));
            rv = m | (10'd1 << p);
            apply0(S, mk(QP2, 4'd4, m, rv, 4'(p)));
            apply0(R, mk(QP2, 4'd4, m, rv, 4'(p + 1)));
            rv = rv | (10'd1 << (p + 1));
            apply0(S, mk(QC, 4'd4, m, rv, 4'(p + 1)));
            m = rv;
            apply0(NOP, mk((p == 8) ? QW : QP1, 4'd4, m, m, 4'(p + 1)));
        end
        apply0(ST, mk(QW,  4'd4, 10'h3FF, 10'h3FF, 4'd9));
        apply0(R,  mk(QW,  4'd4, 10'h3FF, 10'h3FF, 4'd9));
        apply0(AK, mk(QI,  4'd4, 10'h3FF, 10'h3FF, 4'd9));
        apply0(ST, mk(QP1, 4'd5, 10'h000, 10'h000, 4'd0));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL solve step %0d got=%h exp=%h", k, g, e); end
            else $display("solve step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_reset_midshow();
        logic [34:0] e, g;
        apply0(S,   mk(QP2, 4'd5, 10'h0, 10'h001, 4'd0));
        apply0(R,   mk(QP2, 4'd5, 10'h0, 10'h001, 4'd1));
        apply0(R,   mk(QP2, 4'd5, 10'h0, 10'h001, 4'd2));
        apply0(S,   mk(QC,  4'd5, 10'h0, 10'h005, 4'd2));
        apply0(NOP, mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        apply0(NOP, mk(QS,  4'd4, 10'h0, 10'h005, 4'd2));
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        got_q.push_back(obs0());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply0(NOP, mk(QI, 4'd0, 10'h0, 10'h0, 4'd0));
        apply0(ST,  mk(QP1, 4'd5, 10'h0, 10'h0, 4'd0));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL midshow_reset step %0d got=%h exp=%h", k, g, e); end
            else $display("midshow_reset step %0d ok vec=%h", k, g);
        end
    endtask

    task automatic test_lose();
        logic [34:0] e, g;
        apply1(ST,  mk(QP1, 4'd1, 10'h0, 10'h000, 4'd0));
        apply1(S,   mk(QP2, 4'd1, 10'h0, 10'h001, 4'd0));
        apply1(R,   mk(QP2, 4'd1, 10'h0, 10'h001, 4'd1));
        apply1(R,   mk(QP2, 4'd1, 10'h0, 10'h001, 4'd2));
        apply1(S,   mk(QC,  4'd1, 10'h0, 10'h005, 4'd2));
        for (int i = 0; i < 4; i++)
            apply1(NOP, mk(QS, 4'd0, 10'h0, 10'h005, 4'd2));
        apply1(NOP, mk(QL,  4'd0, 10'h0, 10'h000, 4'd2));
        apply1(ST,  mk(QL,  4'd0, 10'h0, 10'h000, 4'd2));
        apply1(AK,  mk(QI,  4'd0, 10'h0, 10'h000, 4'd2));
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
            if (g !== e) begin n_err++; $display("FAIL lose step %0d got=%h exp=%h", k, g, e); end
            else $display("lose step %0d ok vec=%h", k, g);
        end
    endtask

    initial begin
        cards[0] = 4'd3; cards[1] = 4'd3;
        cards[2] = 4'd7; cards[3] = 4'd7;
        cards[4] = 4'd1; cards[5] = 4'd1;
        cards[6] = 4'd2; cards[7] = 4'd2;
        cards[8] = 4'd5; cards[9] = 4'd5;
        test_reset();
        test_cursor();
        test_mismatch();
        test_match();
        test_ignore();
        test_full_solve();
        test_reset_midshow();
        test_lose();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
